// File: rtl/mram_ser_pkg.sv
// Shared types and helpers for the serial MRAM burst engine: FSM states,
// opcode values, shift-register direction selectors and header sizing.
package mram_ser_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    WDATA,
    RLOAD,
    RSHIFT,
    DONE
  } state_e;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam logic DIR_SIPO = 1'b0;
  localparam logic DIR_PISO = 1'b1;

  // Header is op bit, then burst-length field, then start address.
  function automatic int hdr_len(input int addr_w, input int blen_w);
    return 1 + blen_w + addr_w;
  endfunction

endpackage

// File: rtl/ser_shift_reg.sv
// MSB-first shift register used both for serial capture (SIPO) and for
// serial read-back (PISO); parallel load takes priority over shifting.
module ser_shift_reg
  import mram_ser_pkg::*;
#(
  parameter int   W   = 8,
  parameter logic DIR = DIR_SIPO
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_data,
  input  logic         i_shift,
  input  logic         i_ser,
  output logic [W-1:0] o_word,
  output logic         o_msb
);

  logic [W-1:0] r_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, whatever the block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_data;
    end else if (i_shift) begin
      r_q <= {r_q[W-2:0], i_ser};
    end
  end

  // Capture mode exposes the word completed by the bit arriving this cycle,
  // so the owner can act on the same edge that accepts the last bit.
  generate
    if (DIR == DIR_SIPO) begin : g_sipo
      assign o_word = {r_q[W-2:0], i_ser};
    end else begin : g_piso
      assign o_word = r_q;
    end
  endgenerate

  assign o_msb = r_q[W-1];

endmodule

// File: rtl/mram_serial_burst_engine.sv
// Serial-command MRAM front end: decodes op/len/addr frames, writes bursts into
// an on-block word array and streams read bursts back with a valid strobe.
module mram_serial_burst_engine
  import mram_ser_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int BLEN_W = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic ser_in,
  input  logic ser_valid,
  input  logic abort,
  output logic ser_out,
  output logic ser_out_valid,
  output logic busy,
  output logic done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int H     = hdr_len(ADDR_W, BLEN_W);
  localparam int SW    = (H > DATA_W) ? H : DATA_W;
  localparam int CNT_W = $clog2(SW + 1);
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  state_e              r_state;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [BLEN_W:0]     r_word_cnt;
  logic [BLEN_W-1:0]   r_len;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_busy;
  logic                r_done;
  logic                r_out_valid;
  logic                r_wr_pend;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_abort;
  logic                w_accept;
  logic                w_last_word;
  logic [SW-1:0]       w_sipo_word;
  logic                w_sipo_msb_unused;
  logic [DATA_W-1:0]   w_piso_word_unused;
  logic                w_piso_msb;
  logic [H-1:0]        w_hdr;
  logic                w_hdr_op;
  logic [BLEN_W-1:0]   w_hdr_len;
  logic [ADDR_W-1:0]   w_hdr_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W-1:0]   w_rd_data;

  assign w_abort     = abort && (r_state != IDLE);
  assign w_accept    = ser_valid && !w_abort && (r_state inside {IDLE, HDR, WDATA});
  assign w_last_word = (r_word_cnt == {1'b0, r_len});

  assign w_hdr      = w_sipo_word[H-1:0];
  assign w_hdr_op   = w_hdr[H-1];
  assign w_hdr_len  = w_hdr[ADDR_W +: BLEN_W];
  assign w_hdr_addr = w_hdr[ADDR_W-1:0];
  assign w_wdata    = w_sipo_word[DATA_W-1:0];
  assign w_rd_data  = r_mem[r_addr];

  ser_shift_reg #(.W(SW), .DIR(DIR_SIPO)) u_sipo (
    .clk         (clk),
    .rst         (rst),
    .i_load      (1'b0),
    .i_load_data ('0),
    .i_shift     (w_accept),
    .i_ser       (ser_in),
    .o_word      (w_sipo_word),
    .o_msb       (w_sipo_msb_unused)
  );

  ser_shift_reg #(.W(DATA_W), .DIR(DIR_PISO)) u_piso (
    .clk         (clk),
    .rst         (rst),
    .i_load      (r_state == RLOAD),
    .i_load_data (w_rd_data),
    .i_shift     (r_state == RSHIFT),
    .i_ser       (1'b0),
    .o_word      (w_piso_word_unused),
    .o_msb       (w_piso_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_word_cnt  <= '0;
      r_len       <= '0;
      r_addr      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_out_valid <= 1'b0;
      r_wr_pend   <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_wr_pend <= 1'b0;
      if (w_abort) begin
        // A word still being shifted in is dropped; an already staged commit is not.
        r_state     <= IDLE;
        r_busy      <= 1'b0;
        r_done      <= 1'b0;
        r_out_valid <= 1'b0;
        r_bit_cnt   <= '0;
        r_word_cnt  <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              r_state   <= HDR;
              r_busy    <= 1'b1;
              r_bit_cnt <= CNT_W'(1);
            end
          end
          HDR: begin
            if (w_accept) begin
              if (r_bit_cnt == HDR_LAST) begin
                r_len      <= w_hdr_len;
                r_addr     <= w_hdr_addr;
                r_bit_cnt  <= '0;
                r_word_cnt <= '0;
                r_state    <= (w_hdr_op == OP_WRITE) ? WDATA : RLOAD;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
          end
          WDATA: begin
            if (w_accept) begin
              if (r_bit_cnt == DATA_LAST) begin
                r_wr_pend <= 1'b1;
                r_wr_addr <= r_addr;
                r_wr_data <= w_wdata;
                r_addr    <= r_addr + 1'b1;
                r_bit_cnt <= '0;
                if (w_last_word) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
                end else begin
                  r_word_cnt <= r_word_cnt + 1'b1;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end
          end
          RLOAD: begin
            r_state     <= RSHIFT;
            r_out_valid <= 1'b1;
            r_addr      <= r_addr + 1'b1;
            r_bit_cnt   <= '0;
          end
          RSHIFT: begin
            if (r_bit_cnt == DATA_LAST) begin
              r_out_valid <= 1'b0;
              r_bit_cnt   <= '0;
              if (w_last_word) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_state    <= RLOAD;
                r_word_cnt <= r_word_cnt + 1'b1;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
          DONE: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  // NOTE: the array is deliberately reset word by word, because a fresh block
  // must read back zeros; most RAMs would be left unreset to map to macros.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (r_wr_pend) begin
      r_mem[r_wr_addr] <= r_wr_data;
    end
  end

  assign ser_out       = w_piso_msb & r_out_valid;
  assign ser_out_valid = r_out_valid;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_mram_serial_burst_engine.sv
// Directed plus randomized bench for the serial MRAM burst engine, checked
// against a word-array model and the frame timing rules.
module tb_mram_serial_burst_engine;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int BLEN_W = 3;
  localparam int DEPTH  = 16;

  typedef bit bitq_t[$];

  logic clk = 1'b0;
  logic rst;
  logic ser_in;
  logic ser_valid;
  logic abort;
  logic ser_out;
  logic ser_out_valid;
  logic busy;
  logic done;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] model [DEPTH];
  logic [7:0] wbuf  [4];

  mram_serial_burst_engine #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .BLEN_W (BLEN_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ser_in        (ser_in),
    .ser_valid     (ser_valid),
    .abort         (abort),
    .ser_out       (ser_out),
    .ser_out_valid (ser_out_valid),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bitq_t frame_bits(input bit op, input int len, input int addr,
                                       input logic [7:0] w [4]);
    bitq_t q;
    logic [2:0] l3;
    logic [3:0] a4;
    logic [7:0] d8;
    l3 = 3'(len);
    a4 = 4'(addr);
    q.push_back(op);
    for (int b = 2; b >= 0; b--) q.push_back(l3[b]);
    for (int b = 3; b >= 0; b--) q.push_back(a4[b]);
    if (op) begin
      for (int k = 0; k <= len; k++) begin
        d8 = w[k];
        for (int b = 7; b >= 0; b--) q.push_back(d8[b]);
      end
    end
    return q;
  endfunction

  // Drives a bit stream, optionally with random stalls; leaves the bench one
  // cycle after the edge that accepted the final bit.
  task automatic send_bits(input bitq_t q, input bit stall);
    int i;
    int guard;
    bit any;
    bit v;
    i = 0;
    guard = 0;
    any = 1'b0;
    while (i < q.size()) begin
      v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      ser_valid = v;
      ser_in    = v ? q[i] : 1'($urandom);
      tick();
      guard++;
      if (v) begin
        i++;
        any = 1'b1;
      end
      if (i < q.size()) begin
        check("busy_in_frame", busy, any);
        check("no_done_in_frame", done, 0);
        check("no_rdvalid_in_frame", ser_out_valid, 0);
      end
      if (guard > 4000) begin
        $display("FAIL stall_guard: observed %0d cycles expected under 4000", guard);
        $fatal(1, "bit stream never completed");
      end
    end
    ser_valid = 1'b0;
    ser_in    = 1'b0;
  endtask

  task automatic do_write(input int len, input int addr, input bit stall);
    send_bits(frame_bits(1'b1, len, addr, wbuf), stall);
    check("wr_done_pulse", done, 1);
    check("wr_busy_in_done", busy, 1);
    check("wr_no_rdvalid", ser_out_valid, 0);
    for (int k = 0; k <= len; k++) model[(addr + k) % DEPTH] = wbuf[k];
    tick();
    check("wr_done_clear", done, 0);
    check("wr_idle_busy", busy, 0);
  endtask

  task automatic do_read(input int len, input int addr, input bit stall);
    logic [7:0] exp;
    logic [7:0] got;
    send_bits(frame_bits(1'b0, len, addr, wbuf), stall);
    check("rd_load_valid", ser_out_valid, 0);
    check("rd_load_busy", busy, 1);
    check("rd_load_done", done, 0);
    for (int w = 0; w <= len; w++) begin
      exp = model[(addr + w) % DEPTH];
      got = '0;
      for (int b = 7; b >= 0; b--) begin
        tick();
        check("rd_valid", ser_out_valid, 1);
        check("rd_bit", ser_out, exp[b]);
        check("rd_busy", busy, 1);
        got = {got[6:0], ser_out};
      end
      check("rd_word", got, exp);
      tick();
      check("rd_gap_valid", ser_out_valid, 0);
      check("rd_busy_after_word", busy, 1);
      check("rd_done", done, (w == len) ? 1 : 0);
    end
    tick();
    check("rd_idle_busy", busy, 0);
    check("rd_idle_done", done, 0);
  endtask

  initial begin
    bitq_t q;
    int op;
    int len;
    int addr;

    rst = 1'b1;
    ser_valid = 1'b0;
    ser_in = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    for (int k = 0; k < 4; k++) wbuf[k] = 8'h00;
    tick();
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", ser_out_valid, 0);
    check("rst_ser_out", ser_out, 0);
    rst = 1'b0;

    // Single write then read.
    wbuf[0] = 8'hA5;
    do_write(0, 3, 1'b0);
    do_read(0, 3, 1'b0);

    // Burst crossing the top of the array.
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
    do_write(3, 14, 1'b0);
    do_read(3, 14, 1'b0);
    do_read(0, 0, 1'b0);
    do_read(0, 1, 1'b0);

    // Stalled serial input.
    wbuf[0] = 8'hA5;
    do_write(0, 3, 1'b1);
    do_read(0, 3, 1'b1);
    for (int k = 0; k < 4; k++) wbuf[k] = 8'($urandom);
    do_write(2, 9, 1'b1);
    do_read(2, 9, 1'b1);

    // Abort in the middle of the second word of a write.
    wbuf[0] = 8'h5A;
    do_write(0, 6, 1'b0);
    wbuf[0] = 8'h0F; wbuf[1] = 8'hF0;
    q = frame_bits(1'b1, 1, 5, wbuf);
    while (q.size() > 20) void'(q.pop_back());
    send_bits(q, 1'b0);
    abort = 1'b1;
    ser_valid = 1'b1;
    ser_in = 1'b1;
    tick();
    abort = 1'b0;
    ser_valid = 1'b0;
    ser_in = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_valid", ser_out_valid, 0);
    model[5] = 8'h0F;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("abort_no_late_done", done, 0);
      check("abort_stays_idle", busy, 0);
    end
    do_read(1, 5, 1'b0);

    // Randomized frames, each starting the cycle after the previous frame ends.
    for (int n = 0; n < 24; n++) begin
      op   = $urandom_range(0, 1);
      len  = $urandom_range(0, 3);
      addr = $urandom_range(0, DEPTH - 1);
      for (int k = 0; k < 4; k++) wbuf[k] = 8'($urandom);
      if (op == 1) do_write(len, addr, 1'($urandom_range(0, 1)));
      else         do_read(len, addr, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of read-back clears outputs and the array.
    q = frame_bits(1'b0, 2, 3, wbuf);
    send_bits(q, 1'b0);
    tick();
    check("pre_rst_valid", ser_out_valid, 1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrd_rst_valid", ser_out_valid, 0);
    check("midrd_rst_busy", busy, 0);
    check("midrd_rst_done", done, 0);
    check("midrd_rst_ser_out", ser_out, 0);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    do_read(7, 0, 1'b0);
    do_read(7, 8, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
